// File: rtl/cache_pkg.sv
// Shared cache definitions: miss-FSM state codes, line address composition and
// default line geometry.
package cache_pkg;

   localparam int LINE_WORDS_DEF = 4;
   localparam int BEAT_W_DEF     = $clog2(LINE_WORDS_DEF);

   typedef logic [2:0] miss_state_t;

   localparam miss_state_t MISS_IDLE   = 3'd0;
   localparam miss_state_t MISS_SELECT = 3'd1;
   localparam miss_state_t MISS_WB_REQ = 3'd2;
   localparam miss_state_t MISS_RD_REQ = 3'd3;
   localparam miss_state_t MISS_REFILL = 3'd4;
   localparam miss_state_t MISS_DONE   = 3'd5;

   // Line-aligned byte address: tag on top, index below it, offset bits zero.
   function automatic logic [31:0] line_addr(input logic [31:0] tag,
                                             input logic [31:0] index,
                                             input int          tag_w,
                                             input int          idx_w);
      return ((tag << idx_w) | index) << (32 - tag_w - idx_w);
   endfunction

endpackage

// File: rtl/miss_beat_cnt.sv
// Refill beat counter: counts returned beats within a line, wraps naturally at
// 2**BEAT_W, clear has priority over increment.
module miss_beat_cnt
   import cache_pkg::*;
#(
   parameter int BEAT_W = BEAT_W_DEF
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              inc,
   input  logic              clear,
   output logic [BEAT_W-1:0] count
);

   // NOTE: sequential state is written with <= only, so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Miss-handling controller for one set-associative cache: victim select,
// optional writeback, line read and refill. Define CACHE_MISS_CTRL_PERF_EN
// to add the perf_miss_cnt / perf_wb_cnt event counters.
module cache_miss_ctrl
   import cache_pkg::*;
#(
   parameter  int NUM_WAY    = 2,
   parameter  int TAG_W      = 20,
   parameter  int IDX_W      = 8,
   parameter  int LINE_WORDS = LINE_WORDS_DEF,
   parameter  int DATA_W     = 32,
   localparam int BEAT_W     = $clog2(LINE_WORDS)
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               miss_valid,
   output logic               miss_ready,
   input  logic [IDX_W-1:0]   miss_index,
   input  logic [TAG_W-1:0]   miss_tag,
   input  logic [NUM_WAY-1:0] v_ways,
   input  logic [NUM_WAY-1:0] d_ways,
   output logic               repl_en,
   input  logic [NUM_WAY-1:0] repl_way,
   input  logic [TAG_W-1:0]   victim_tag,
   output logic [NUM_WAY-1:0] victim_way,
   output logic               wr_req,
   input  logic               wr_rdy,
   output logic [31:0]        wr_addr,
   output logic               rd_req,
   input  logic               rd_rdy,
   output logic [31:0]        rd_addr,
   input  logic               ret_valid,
   input  logic               ret_last,
   input  logic [DATA_W-1:0]  ret_data,
   output logic               refill_we,
   output logic [IDX_W-1:0]   refill_index,
   output logic [BEAT_W-1:0]  refill_word,
   output logic [DATA_W-1:0]  refill_data,
   output logic               done
`ifdef CACHE_MISS_CTRL_PERF_EN
   ,
   output logic [31:0]        perf_miss_cnt,
   output logic [31:0]        perf_wb_cnt
`endif
);

   miss_state_t        state_q, state_d;
   logic [IDX_W-1:0]   index_q;
   logic [TAG_W-1:0]   tag_q;
   logic [TAG_W-1:0]   vtag_q;
   logic [NUM_WAY-1:0] v_q, d_q, way_q;
   logic               accept;
   logic               wb_need;
   logic               beat_inc, beat_clear;

   assign accept  = miss_valid && miss_ready;
   // Valid gates dirty: an invalid line never needs writing back.
   assign wb_need = |(repl_way & v_q & d_q);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= MISS_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         MISS_IDLE:   if (miss_valid) state_d = MISS_SELECT;
         MISS_SELECT: state_d = wb_need ? MISS_WB_REQ : MISS_RD_REQ;
         MISS_WB_REQ: if (wr_rdy) state_d = MISS_RD_REQ;
         MISS_RD_REQ: if (rd_rdy) state_d = MISS_REFILL;
         MISS_REFILL: if (ret_valid && ret_last) state_d = MISS_DONE;
         MISS_DONE:   state_d = MISS_IDLE;
         default:     state_d = MISS_IDLE;
      endcase
   end

   always_comb begin
      // NOTE: every output gets a default before the case so no path infers a latch.
      miss_ready = 1'b0;
      repl_en    = 1'b0;
      wr_req     = 1'b0;
      rd_req     = 1'b0;
      refill_we  = 1'b0;
      done       = 1'b0;
      case (state_q)
         MISS_IDLE:   miss_ready = 1'b1;
         MISS_SELECT: repl_en    = 1'b1;
         MISS_WB_REQ: wr_req     = 1'b1;
         MISS_RD_REQ: rd_req     = 1'b1;
         MISS_REFILL: refill_we  = ret_valid;
         MISS_DONE:   done       = 1'b1;
         default:     ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         index_q <= '0;
         tag_q   <= '0;
         v_q     <= '0;
         d_q     <= '0;
         way_q   <= '0;
         vtag_q  <= '0;
      end else begin
         if (accept) begin
            index_q <= miss_index;
            tag_q   <= miss_tag;
            v_q     <= v_ways;
            d_q     <= d_ways;
         end
         if (state_q == MISS_SELECT) begin
            way_q  <= repl_way;
            vtag_q <= victim_tag;
         end
      end
   end

   // Addresses come straight from latched fields, so they hold while a request is up.
   assign wr_addr      = line_addr(32'(vtag_q), 32'(index_q), TAG_W, IDX_W);
   assign rd_addr      = line_addr(32'(tag_q), 32'(index_q), TAG_W, IDX_W);
   assign victim_way   = way_q;
   assign refill_index = index_q;
   assign refill_data  = (state_q == MISS_REFILL) ? ret_data : '0;

   assign beat_inc   = (state_q == MISS_REFILL) && ret_valid;
   assign beat_clear = beat_inc && ret_last;

   miss_beat_cnt #(
      .BEAT_W (BEAT_W)
   ) u_beat_cnt (
      .clk    (clk),
      .resetn (resetn),
      .inc    (beat_inc),
      .clear  (beat_clear),
      .count  (refill_word)
   );

`ifdef CACHE_MISS_CTRL_PERF_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         perf_miss_cnt <= '0;
         perf_wb_cnt   <= '0;
      end else begin
         if (accept) perf_miss_cnt <= perf_miss_cnt + 32'd1;
         if (wr_req && wr_rdy) perf_wb_cnt <= perf_wb_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Self-checking bench for cache_miss_ctrl: directed misses plus randomized ones,
// checked against a transaction-level model of the miss protocol.
module tb_cache_miss_ctrl;

   localparam int IDX_W = 8;
   localparam int TAG_W = 20;

   logic             clk = 1'b0;
   logic             resetn;
   logic             miss_valid;
   logic             miss_ready;
   logic [IDX_W-1:0] miss_index;
   logic [TAG_W-1:0] miss_tag;
   logic [1:0]       v_ways, d_ways;
   logic             repl_en;
   logic [1:0]       repl_way;
   logic [TAG_W-1:0] victim_tag;
   logic [1:0]       victim_way;
   logic             wr_req, wr_rdy;
   logic [31:0]      wr_addr;
   logic             rd_req, rd_rdy;
   logic [31:0]      rd_addr;
   logic             ret_valid, ret_last;
   logic [31:0]      ret_data;
   logic             refill_we;
   logic [IDX_W-1:0] refill_index;
   logic [1:0]       refill_word;
   logic [31:0]      refill_data;
   logic             done;
`ifdef CACHE_MISS_CTRL_PERF_EN
   logic [31:0]      perf_miss_cnt, perf_wb_cnt;
`endif

   int          cmp_cnt = 0;
   int          err_cnt = 0;
   int          model_miss = 0;
   int          model_wb = 0;
   int          gap_q[4];
   logic [31:0] beat_q[4];

   always #5 clk = ~clk;

   cache_miss_ctrl dut (
      .clk          (clk),
      .resetn       (resetn),
      .miss_valid   (miss_valid),
      .miss_ready   (miss_ready),
      .miss_index   (miss_index),
      .miss_tag     (miss_tag),
      .v_ways       (v_ways),
      .d_ways       (d_ways),
      .repl_en      (repl_en),
      .repl_way     (repl_way),
      .victim_tag   (victim_tag),
      .victim_way   (victim_way),
      .wr_req       (wr_req),
      .wr_rdy       (wr_rdy),
      .wr_addr      (wr_addr),
      .rd_req       (rd_req),
      .rd_rdy       (rd_rdy),
      .rd_addr      (rd_addr),
      .ret_valid    (ret_valid),
      .ret_last     (ret_last),
      .ret_data     (ret_data),
      .refill_we    (refill_we),
      .refill_index (refill_index),
      .refill_word  (refill_word),
      .refill_data  (refill_data),
      .done         (done)
`ifdef CACHE_MISS_CTRL_PERF_EN
      ,
      .perf_miss_cnt(perf_miss_cnt),
      .perf_wb_cnt  (perf_wb_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string pfx);
      check({pfx, "_miss_ready"}, 32'(miss_ready), 32'd1);
      check({pfx, "_repl_en"}, 32'(repl_en), 32'd0);
      check({pfx, "_wr_req"}, 32'(wr_req), 32'd0);
      check({pfx, "_rd_req"}, 32'(rd_req), 32'd0);
      check({pfx, "_refill_we"}, 32'(refill_we), 32'd0);
      check({pfx, "_done"}, 32'(done), 32'd0);
      check({pfx, "_victim_way"}, 32'(victim_way), 32'd0);
      check({pfx, "_wr_addr"}, wr_addr, 32'd0);
      check({pfx, "_rd_addr"}, rd_addr, 32'd0);
      check({pfx, "_refill_word"}, 32'(refill_word), 32'd0);
      check({pfx, "_refill_index"}, 32'(refill_index), 32'd0);
      check({pfx, "_refill_data"}, refill_data, 32'd0);
   endtask

   // One full miss transaction; beats/gaps come from beat_q/gap_q. abort_at>=0
   // pulls resetn low just before that beat and ends the transaction there.
   task automatic run_miss(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                           input logic [1:0] v, input logic [1:0] d, input logic [1:0] repl,
                           input logic [TAG_W-1:0] vtag, input int wr_wait, input int rd_wait,
                           input int abort_at, input bit busy_valid);
      bit          wb;
      logic [31:0] exp_wr, exp_rd;
      int          cyc, exp_lat;
      wb      = (repl & v & d) != 2'b00;
      exp_wr  = 32'(vtag) * 32'd4096 + 32'(idx) * 32'd16;
      exp_rd  = 32'(tag) * 32'd4096 + 32'(idx) * 32'd16;
      exp_lat = 7 + rd_wait + (wb ? wr_wait + 1 : 0);
      for (int b = 0; b < 4; b++) exp_lat += gap_q[b];

      miss_valid = 1'b1; miss_index = idx; miss_tag = tag; v_ways = v; d_ways = d;
      #1 check("accept_ready", 32'(miss_ready), 32'd1);
      @(negedge clk);
      cyc = 1;
      model_miss++;
      // SELECT: scramble request inputs so only latched values can be right.
      miss_valid = busy_valid; miss_index = ~idx; miss_tag = ~tag; v_ways = ~v; d_ways = ~d;
      repl_way = repl; victim_tag = vtag; ret_valid = 1'b1; ret_data = $urandom;
      #1;
      check("sel_repl_en", 32'(repl_en), 32'd1);
      check("sel_ready", 32'(miss_ready), 32'd0);
      check("sel_refill_we", 32'(refill_we), 32'd0);
      check("sel_wr_req", 32'(wr_req), 32'd0);
      @(negedge clk);
      cyc++;
      repl_way = ~repl; victim_tag = ~vtag; ret_valid = 1'b0;
      if (wb) begin
         for (int k = 0; k <= wr_wait; k++) begin
            wr_rdy = (k == wr_wait);
            #1;
            check("wb_wr_req", 32'(wr_req), 32'd1);
            check("wb_wr_addr", wr_addr, exp_wr);
            check("wb_rd_req", 32'(rd_req), 32'd0);
            check("wb_repl_en", 32'(repl_en), 32'd0);
            @(negedge clk);
            cyc++;
         end
         wr_rdy = 1'b0;
         model_wb++;
      end
      for (int k = 0; k <= rd_wait; k++) begin
         rd_rdy = (k == rd_wait);
         #1;
         check("rd_rd_req", 32'(rd_req), 32'd1);
         check("rd_rd_addr", rd_addr, exp_rd);
         check("rd_wr_req", 32'(wr_req), 32'd0);
         check("rd_refill_we", 32'(refill_we), 32'd0);
         @(negedge clk);
         cyc++;
      end
      rd_rdy = 1'b0; miss_valid = 1'b0;
      for (int b = 0; b < 4; b++) begin
         if (b == abort_at) begin
            resetn = 1'b0; ret_data = $urandom;
            #1 check_idle("abort");
            @(negedge clk);
            resetn = 1'b1;
            model_miss = 0; model_wb = 0;
            #1;
            check("abort_no_reissue_rd", 32'(rd_req), 32'd0);
            check("abort_no_reissue_wr", 32'(wr_req), 32'd0);
            return;
         end
         for (int g = 0; g < gap_q[b]; g++) begin
            ret_valid = 1'b0; ret_last = 1'($urandom); ret_data = $urandom;
            #1;
            check("gap_refill_we", 32'(refill_we), 32'd0);
            check("gap_word", 32'(refill_word), 32'(b));
            check("gap_done", 32'(done), 32'd0);
            @(negedge clk);
            cyc++;
         end
         ret_valid = 1'b1; ret_last = (b == 3); ret_data = beat_q[b];
         #1;
         check("beat_refill_we", 32'(refill_we), 32'd1);
         check("beat_word", 32'(refill_word), 32'(b));
         check("beat_data", refill_data, beat_q[b]);
         check("beat_index", 32'(refill_index), 32'(idx));
         check("beat_victim_way", 32'(victim_way), 32'(repl));
         check("beat_done", 32'(done), 32'd0);
         @(negedge clk);
         cyc++;
      end
      ret_valid = 1'b0; ret_last = 1'b0;
      #1;
      check("done_pulse", 32'(done), 32'd1);
      check("done_latency", 32'(cyc), 32'(exp_lat));
      check("done_victim_way", 32'(victim_way), 32'(repl));
      check("done_refill_we", 32'(refill_we), 32'd0);
      check("done_ready", 32'(miss_ready), 32'd0);
      @(negedge clk);
      #1;
      check("post_done", 32'(done), 32'd0);
      check("post_ready", 32'(miss_ready), 32'd1);
   endtask

   initial begin
      resetn = 1'b0; miss_valid = 1'b0; miss_index = '0; miss_tag = '0;
      v_ways = '0; d_ways = '0; repl_way = '0; victim_tag = '0;
      wr_rdy = 1'b0; rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0;
      ret_data = 32'hDEAD_BEEF;
      #3 check_idle("reset");
      @(negedge clk);
      resetn = 1'b1;

      // Clean miss, fastest path.
      gap_q = '{0, 0, 0, 0};
      beat_q = '{32'h11, 32'h22, 32'h33, 32'h44};
      run_miss(8'h12, 20'hABCDE, 2'b01, 2'b00, 2'b10, 20'h00000, 0, 0, -1, 1'b0);
      check("t1_rd_addr_const", rd_addr, 32'hABCDE120);

      // Dirty victim, wr_rdy after three wait cycles.
      run_miss(8'h12, 20'h54321, 2'b11, 2'b11, 2'b01, 20'h12345, 3, 0, -1, 1'b1);
      check("t2_wr_addr_const", wr_addr, 32'h12345120);

      // Invalid-but-dirty victim: no writeback.
      run_miss(8'h34, 20'h0F0F0, 2'b01, 2'b10, 2'b10, 20'hFFFFF, 0, 1, -1, 1'b0);

      // Return gaps: beats on cycles 0,2,5,6.
      gap_q = '{0, 1, 2, 0};
      beat_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
      run_miss(8'h56, 20'h13579, 2'b10, 2'b10, 2'b10, 20'h2468A, 1, 0, -1, 1'b1);

      // Reset mid-refill after two beats, then a fresh miss from word 0.
      gap_q = '{0, 0, 0, 0};
      run_miss(8'h78, 20'h11111, 2'b11, 2'b01, 2'b01, 20'h22222, 0, 0, 2, 1'b0);
      beat_q = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
      run_miss(8'h9A, 20'h33333, 2'b00, 2'b11, 2'b01, 20'h44444, 0, 0, -1, 1'b0);

      for (int n = 0; n < 16; n++) begin
         for (int b = 0; b < 4; b++) begin
            gap_q[b]  = int'($urandom_range(0, 2));
            beat_q[b] = $urandom;
         end
         run_miss(8'($urandom), 20'($urandom), 2'($urandom), 2'($urandom),
                  2'b01 << $urandom_range(0, 1), 20'($urandom),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1, 1'($urandom));
      end

`ifdef CACHE_MISS_CTRL_PERF_EN
      check("perf_miss_cnt", perf_miss_cnt, 32'(model_miss));
      check("perf_wb_cnt", perf_wb_cnt, 32'(model_wb));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
